fg_bbox: RTL and testbench
==========================

# fg_bbox

Per-frame foreground bounding-box extractor sitting directly downstream of the colour-classification stage. It consumes the classified pixel stream, where `i_wb` = 0 marks a matched (foreground) pixel. It tracks pixel coordinates, accumulates min/max X/Y and the foreground pixel count, and publishes one result set per complete frame.

## Interface
Parameters:
- `H_ACT`, 1280, active pixels per line
- `V_ACT`, 720, active lines per frame
- `X_W`, 11, X coordinate width; must satisfy 2^X_W ≥ H_ACT
- `Y_W`, 10, Y coordinate width; must satisfy 2^Y_W ≥ V_ACT
- `CNT_W`, 21, pixel counter width; must satisfy 2^CNT_W > H_ACT·V_ACT
- `MIN_PIX`, 64, minimum foreground count for `o_found` = 1
- `RUN_LEN`, 4, run length used by the noise filter (≥ 2)

Ports:
- `sys_clk`  in  1  clock
- `sys_rst_n`  in  1  reset, asynchronous, active-low
- `i_vs`  in  1  frame-start pulse
- `i_valid`  in  1  pixel qualifier
- `i_wb`  in  1  0 = foreground, 1 = background
- `o_box_valid`  out  1  one-cycle result strobe
- `o_found`  out  1  `o_pix_cnt` ≥ MIN_PIX
- `o_x_min`, `o_x_max`  out  X_W  box columns, inclusive
- `o_y_min`, `o_y_max`  out  Y_W  box rows, inclusive
- `o_pix_cnt`  out  CNT_W  counted foreground pixels
- `o_frame_err`  out  1  one-cycle pulse: frame aborted

## Operation
- States:
  - WAIT: after reset, ignores pixels until `i_vs`.
  - ACTIVE: counting.
  - FLUSH: one cycle, result latch.
- WAIT→ACTIVE on `i_vs`. A pixel with `i_valid` in the same cycle as `i_vs` is pixel (0,0) of the new frame.
- ACTIVE:
  - Each `i_valid` advances x; x wraps at H_ACT−1 → 0 and y increments.
  - After the pixel at (H_ACT−1, V_ACT−1) → FLUSH.
- FLUSH:
  - Latches accumulators into outputs and pulses `o_box_valid`.
  - Goes to WAIT, or to ACTIVE if `i_vs` is present this cycle.
- `i_vs` in ACTIVE (mid-frame):
  - Pulses `o_frame_err`.
  - Discards accumulators without updating outputs.
  - Restarts at (0,0) using this cycle's pixel.
- Pixels after the frame end and before the next `i_vs` are ignored.
- Accumulator reset at each frame start: x_min = H_ACT−1, y_min = V_ACT−1, max = 0, cnt = 0.
- Counted pixel rule: min/max updates compare against the current coordinate; cnt increments by 1. Counter saturates at all-ones.
- Empty frame (cnt < MIN_PIX):
  - `o_found` = 0.
  - Box outputs show the raw accumulators (min > max when cnt = 0).
- Output hold: outputs hold between strobes. `o_found` is registered together with the box.

## Timing
- Reset values of all outputs: 0. State = WAIT, x = y = 0.
- Accumulators update one cycle after the pixel is sampled.
- Last pixel sampled at edge N:
  - FLUSH occupies cycle N+1.
  - `o_box_valid` = 1 and outputs are updated for the cycle after edge N+2. That is 2 cycles of latency.
- `o_frame_err` is high the cycle after the aborting `i_vs` edge.
- `i_valid` may be gapped arbitrarily; no backpressure.
- Reset mid-frame: immediate return to WAIT, no strobe.

## Configuration
- `FG_BBOX_RUN_FILTER_EN` defined:
  - A per-line run counter counts consecutive foreground pixels. It is cleared on each background pixel and at x = 0.
  - When the run reaches RUN_LEN: x_min is compared with x−(RUN_LEN−1) and cnt += RUN_LEN.
  - Further pixels in the same run count individually.
  - Shorter runs are discarded.
- Undefined: every foreground pixel counts. The run counter is not built.

## Test plan
Bench parameters: H_ACT = 8, V_ACT = 4, MIN_PIX = 2, RUN_LEN = 3.
- Single frame, foreground at x = 2..5 on rows 1 and 2, filter off → `o_box_valid` 2 cycles after the last pixel; x 2..5, y 1..2, cnt = 8, found = 1.
- All-background frame → cnt = 0, found = 0, x_min = 7, x_max = 0, y_min = 3, y_max = 0.
- `i_vs` after 10 pixels, then a full frame with one foreground pixel at (7,3) → `o_frame_err` pulse, no strobe for the aborted frame; second frame gives box (7,7,3,3), cnt = 1, found = 0.
- Filter on, row 0 runs: x = 0..1 (length 2) and x = 4..6 (length 3) → x 4..6, cnt = 3, found = 1.
- Gapped `i_valid` (1 of 3 cycles) over the first scenario's frame → identical results; extra pixels after frame end are ignored.
- Reset asserted mid-frame, then a clean frame → no strobe before the clean frame; outputs read 0 until its strobe.

Source files
------------

// File: rtl/fg_bbox.sv
// fg_bbox: per-frame foreground bounding box and pixel count over a classified pixel stream.
// Optional run-length noise filter is enabled by defining FG_BBOX_RUN_FILTER_EN.
module fg_bbox #(
  parameter int H_ACT   = 1280,
  parameter int V_ACT   = 720,
  parameter int X_W     = 11,
  parameter int Y_W     = 10,
  parameter int CNT_W   = 21,
  parameter int MIN_PIX = 64,
  parameter int RUN_LEN = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             i_vs,
  input  logic             i_valid,
  input  logic             i_wb,
  output logic             o_box_valid,
  output logic             o_found,
  output logic [X_W-1:0]   o_x_min,
  output logic [X_W-1:0]   o_x_max,
  output logic [Y_W-1:0]   o_y_min,
  output logic [Y_W-1:0]   o_y_max,
  output logic [CNT_W-1:0] o_pix_cnt,
  output logic             o_frame_err
);

  // Stream: i_valid qualifies i_wb in the same cycle; there is no ready, every qualified pixel is consumed.
  localparam int INC_W = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d, cur_x, x_lo;
  logic [Y_W-1:0]   y_q, y_d, cur_y;
  logic             in_frame, pix, frame_end, abort;
  logic             cnt_en;
  logic [INC_W-1:0] inc_d;

  // i_vs always restarts the coordinate walk, so this cycle's pixel is (0,0).
  always_comb begin
    cur_x     = i_vs ? '0 : x_q;
    cur_y     = i_vs ? '0 : y_q;
    in_frame  = i_vs || (state_q == S_ACTIVE);
    pix       = in_frame && i_valid;
    abort     = i_vs && (state_q == S_ACTIVE);
    frame_end = pix && (cur_x == X_W'(H_ACT - 1)) && (cur_y == Y_W'(V_ACT - 1));
    x_d       = cur_x;
    y_d       = cur_y;
    if (pix) begin
      if (cur_x == X_W'(H_ACT - 1)) begin
        x_d = '0;
        y_d = (cur_y == Y_W'(V_ACT - 1)) ? '0 : cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
      end
    end
    state_d = state_q;
    if (frame_end)                state_d = S_FLUSH;
    else if (in_frame)            state_d = S_ACTIVE;
    else if (state_q == S_FLUSH)  state_d = S_WAIT;
  end

`ifdef FG_BBOX_RUN_FILTER_EN
  logic [INC_W-1:0] run_q, run_prev, run_d;

  // A run only counts once it reaches RUN_LEN; its first qualifying pixel back-fills the run.
  always_comb begin
    run_prev = (cur_x == '0) ? '0 : run_q;
    run_d    = run_q;
    cnt_en   = 1'b0;
    inc_d    = INC_W'(1);
    x_lo     = cur_x;
    if (pix) begin
      if (!i_wb) begin
        run_d  = (run_prev == INC_W'(RUN_LEN)) ? run_prev : run_prev + 1'b1;
        cnt_en = (run_d == INC_W'(RUN_LEN));
        if (run_prev == INC_W'(RUN_LEN - 1)) begin
          inc_d = INC_W'(RUN_LEN);
          x_lo  = cur_x - X_W'(RUN_LEN - 1);
        end
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) run_q <= '0;
    else            run_q <= run_d;
  end
`else
  always_comb begin
    cnt_en = pix && !i_wb;
    inc_d  = INC_W'(1);
    x_lo   = cur_x;
  end
`endif

  logic             p_clr, p_cnt, latch_pend;
  logic [INC_W-1:0] p_inc;
  logic [X_W-1:0]   p_xlo, p_x;
  logic [Y_W-1:0]   p_y;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_WAIT;
      x_q         <= '0;
      y_q         <= '0;
      p_clr       <= 1'b0;
      p_cnt       <= 1'b0;
      p_inc       <= '0;
      p_xlo       <= '0;
      p_x         <= '0;
      p_y         <= '0;
      latch_pend  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      p_clr       <= i_vs;
      p_cnt       <= cnt_en;
      p_inc       <= inc_d;
      p_xlo       <= x_lo;
      p_x         <= cur_x;
      p_y         <= cur_y;
      latch_pend  <= (state_q == S_FLUSH);
      o_frame_err <= abort;
    end
  end

  logic [X_W-1:0]   acc_xmin, acc_xmax, b_xmin, b_xmax, n_xmin, n_xmax;
  logic [Y_W-1:0]   acc_ymin, acc_ymax, b_ymin, b_ymax, n_ymin, n_ymax;
  logic [CNT_W-1:0] acc_cnt, b_cnt, n_cnt;
  logic [CNT_W:0]   sum;

  // A frame start seeds the accumulators before the pipelined pixel is folded in.
  always_comb begin
    b_xmin = p_clr ? X_W'(H_ACT - 1) : acc_xmin;
    b_xmax = p_clr ? '0 : acc_xmax;
    b_ymin = p_clr ? Y_W'(V_ACT - 1) : acc_ymin;
    b_ymax = p_clr ? '0 : acc_ymax;
    b_cnt  = p_clr ? '0 : acc_cnt;
    n_xmin = b_xmin;
    n_xmax = b_xmax;
    n_ymin = b_ymin;
    n_ymax = b_ymax;
    n_cnt  = b_cnt;
    sum    = {1'b0, b_cnt} + (CNT_W + 1)'(p_inc);
    if (p_cnt) begin
      if (p_xlo < b_xmin) n_xmin = p_xlo;
      if (p_x > b_xmax)   n_xmax = p_x;
      if (p_y < b_ymin)   n_ymin = p_y;
      if (p_y > b_ymax)   n_ymax = p_y;
      n_cnt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_xmin <= X_W'(H_ACT - 1);
      acc_xmax <= '0;
      acc_ymin <= Y_W'(V_ACT - 1);
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else begin
      acc_xmin <= n_xmin;
      acc_xmax <= n_xmax;
      acc_ymin <= n_ymin;
      acc_ymax <= n_ymax;
      acc_cnt  <= n_cnt;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      o_box_valid <= 1'b0;
      o_found     <= 1'b0;
      o_x_min     <= '0;
      o_x_max     <= '0;
      o_y_min     <= '0;
      o_y_max     <= '0;
      o_pix_cnt   <= '0;
    end else begin
      o_box_valid <= latch_pend;
      if (latch_pend) begin
        o_found   <= (acc_cnt >= CNT_W'(MIN_PIX));
        o_x_min   <= acc_xmin;
        o_x_max   <= acc_xmax;
        o_y_min   <= acc_ymin;
        o_y_max   <= acc_ymax;
        o_pix_cnt <= acc_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fg_bbox.sv
// tb_fg_bbox: table-driven frames with a timed scoreboard of expected result strobes for fg_bbox.
module tb_fg_bbox;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       i_vs, i_valid, i_wb;
  logic       o_box_valid, o_found, o_frame_err;
  logic [2:0] o_x_min, o_x_max;
  logic [1:0] o_y_min, o_y_max;
  logic [5:0] o_pix_cnt;

  fg_bbox #(
    .H_ACT(8), .V_ACT(4), .X_W(3), .Y_W(2), .CNT_W(6), .MIN_PIX(2), .RUN_LEN(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .i_vs(i_vs), .i_valid(i_valid), .i_wb(i_wb),
    .o_box_valid(o_box_valid), .o_found(o_found),
    .o_x_min(o_x_min), .o_x_max(o_x_max),
    .o_y_min(o_y_min), .o_y_max(o_y_max),
    .o_pix_cnt(o_pix_cnt), .o_frame_err(o_frame_err)
  );

  // clock / reset
  int cyc = 0;
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: {x_min, x_max, y_min, y_max, cnt, found, strobe_cycle}
  logic [48:0] exp_q[$];
  int          err_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] mask;
    int          gap;
    int          extra;
    int          idle;
    logic [16:0] box;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [16:0] mk_box(input int xmin, xmax, ymin, ymax, cnt, input logic found);
    return {3'(xmin), 3'(xmax), 2'(ymin), 2'(ymax), 6'(cnt), found};
  endfunction

  function automatic vec_t mk_vec(input logic [31:0] mask, input int gap, extra, idle,
                                  input logic [16:0] box);
    vec_t v;
    v.mask = mask; v.gap = gap; v.extra = extra; v.idle = idle; v.box = box;
    return v;
  endfunction

  // driver tasks
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      i_vs = 1'b0; i_valid = 1'b0; i_wb = 1'b1;
    end
  endtask

  task automatic partial(input int n);
    for (int p = 0; p < n; p++) begin
      @(negedge sys_clk);
      i_vs = (p == 0); i_valid = 1'b1; i_wb = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] mask, input int gap, input int extra,
                            input logic abort, input logic [16:0] box);
    for (int p = 0; p < 32; p++) begin
      @(negedge sys_clk);
      i_vs = (p == 0); i_valid = 1'b1; i_wb = ~mask[p];
      if (p == 0 && abort) err_q.push_back(cyc + 1);
      if (p == 31) exp_q.push_back({box, 32'(cyc + 3)});
      for (int g = 0; g < gap; g++) begin
        @(negedge sys_clk);
        i_vs = 1'b0; i_valid = 1'b0; i_wb = 1'($urandom_range(0, 1));
      end
    end
    for (int e = 0; e < extra; e++) begin
      @(negedge sys_clk);
      i_vs = 1'b0; i_valid = 1'b1; i_wb = 1'b0;
    end
  endtask

  // monitor
  logic        box_hit, err_hit;
  logic [48:0] e;
  always @(posedge sys_clk) begin
    #1;
    box_hit = (exp_q.size() > 0) && (exp_q[0][31:0] == cyc);
    err_hit = (err_q.size() > 0) && (err_q[0] == cyc);
    if (o_box_valid || box_hit) begin
      check("box_valid_strobe", o_box_valid, box_hit);
      if (box_hit) begin
        e = exp_q.pop_front();
        check("x_min",   o_x_min,   e[48:46]);
        check("x_max",   o_x_max,   e[45:43]);
        check("y_min",   o_y_min,   e[42:41]);
        check("y_max",   o_y_max,   e[40:39]);
        check("pix_cnt", o_pix_cnt, e[38:33]);
        check("found",   o_found,   e[32]);
      end
    end
    if (o_frame_err || err_hit) begin
      check("frame_err_pulse", o_frame_err, err_hit);
      if (err_hit) void'(err_q.pop_front());
    end
  end

  logic [16:0] box_f1, box_row0, box_single;

  initial begin
    sys_rst_n = 1'b0; i_vs = 1'b0; i_valid = 1'b0; i_wb = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_box_valid", o_box_valid, 0);
    check("rst_found",     o_found,     0);
    check("rst_x_min",     o_x_min,     0);
    check("rst_x_max",     o_x_max,     0);
    check("rst_y_min",     o_y_min,     0);
    check("rst_y_max",     o_y_max,     0);
    check("rst_pix_cnt",   o_pix_cnt,   0);
    check("rst_frame_err", o_frame_err, 0);
    sys_rst_n = 1'b1;

    box_f1 = mk_box(2, 5, 1, 2, 8, 1'b1);
`ifdef FG_BBOX_RUN_FILTER_EN
    box_row0   = mk_box(4, 6, 0, 0, 3, 1'b1);
    box_single = mk_box(7, 0, 3, 0, 0, 1'b0);
`else
    box_row0   = mk_box(0, 6, 0, 0, 5, 1'b1);
    box_single = mk_box(7, 7, 3, 3, 1, 1'b0);
`endif
    // frame 0 runs straight into frame 1: its i_vs lands in the flush cycle
    vecs[0] = mk_vec(32'h003C_3C00, 0, 0, 0, box_f1);
    vecs[1] = mk_vec(32'h0000_0000, 0, 0, 3, mk_box(7, 0, 3, 0, 0, 1'b0));
    vecs[2] = mk_vec(32'h0000_0073, 0, 0, 2, box_row0);
    vecs[3] = mk_vec(32'h003C_3C00, 2, 5, 2, box_f1);

    idle(2);
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].mask, vecs[i].gap, vecs[i].extra, 1'b0, vecs[i].box);
      idle(vecs[i].idle);
    end

    // mid-frame abort: 10 foreground pixels are discarded, no strobe for them
    idle(3);
    partial(10);
    send_frame(32'h8000_0000, 0, 0, 1'b1, box_single);
    idle(5);

    // reset mid-frame returns everything to zero and drops the partial frame
    partial(12);
    @(negedge sys_clk);
    sys_rst_n = 1'b0; i_vs = 1'b0; i_valid = 1'b0;
    #1;
    check("midrst_x_min",   o_x_min,   0);
    check("midrst_x_max",   o_x_max,   0);
    check("midrst_y_min",   o_y_min,   0);
    check("midrst_pix_cnt", o_pix_cnt, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(2);
    send_frame(32'h003C_3C00, 0, 0, 1'b0, box_f1);
    @(posedge sys_clk);
    #1;
    check("pre_strobe_valid",   o_box_valid, 0);
    check("pre_strobe_x_max",   o_x_max,     0);
    check("pre_strobe_pix_cnt", o_pix_cnt,   0);
    check("pre_strobe_found",   o_found,     0);
    idle(8);

    check("pending_strobes", exp_q.size(), 0);
    check("pending_errs",    err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
